// File: rtl/i2s_rx_slave_deserializer_if.sv
// I2S RX bus bundle: serial pins from the TX master plus the frame valid/ready output.
// Latency: none (wiring only).
// Backpressure: frame_ready from the consumer; the serial side cannot be stalled.
//
// Ports (signals):
//   sclk, ws, sd        serial clock, word select (0=left, 1=right), serial data
//   left_data/right_data  frame words, DATA_WIDTH bits each
//   frame_valid/frame_ready  frame handshake
//   overrun_err         single-cycle pulse when a pending frame is overwritten
// Modports: master = TX/consumer side, slave = deserializer side.
interface i2s_rx_slave_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sclk;
  logic                  ws;
  logic                  sd;
  logic [DATA_WIDTH-1:0] left_data;
  logic [DATA_WIDTH-1:0] right_data;
  logic                  frame_valid;
  logic                  frame_ready;
  logic                  overrun_err;

  modport master (
    output sclk, ws, sd, frame_ready,
    input  left_data, right_data, frame_valid, overrun_err
  );

  modport slave (
    input  sclk, ws, sd, frame_ready,
    output left_data, right_data, frame_valid, overrun_err
  );
endinterface

// File: rtl/i2s_rx_slave_deserializer.sv
// I2S slave receiver: oversamples SCLK/WS/SD, rebuilds Philips-format words, emits L/R frames.
// Latency: frame outputs update 4 clk after the pad SCLK rise that carries the closing WS edge.
// Backpressure: frame held while valid && !ready; a newer frame overwrites it and pulses overrun_err.
//
// Ports:
//   clk_i     system clock, at least 4x SCLK
//   rst_i     synchronous active-high reset
//   enable_i  1 = receive, 0 = return to IDLE (partial word and WS sync dropped)
//   bus       slave modport: sclk/ws/sd in, frame words + valid/ready + overrun_err
//   state_o   1=RESET_ACTIVATED, 2=IDLE, 3=LEFT_CHANNEL, 4=RIGHT_CHANNEL
module i2s_rx_slave_deserializer #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_OF_CHANNELS = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           enable_i,
  i2s_rx_slave_deserializer_if.slave     bus,
  output logic [2:0]                     state_o
);

  typedef enum logic [2:0] {
    ST_RESET = 3'd1,
    ST_IDLE  = 3'd2,
    ST_LEFT  = 3'd3,
    ST_RIGHT = 3'd4
  } state_e;

  localparam int             CW   = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]  DW_C = CW'(DATA_WIDTH);
  localparam bit             MONO = (NUM_OF_CHANNELS == 1);

  // Input synchronizers (two flops each) plus a third SCLK flop for rise detection.
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic ws_s1_q, ws_s2_q;
  logic sd_s1_q, sd_s2_q;

  // Deserializer state.
  state_e                state_q, state_d;
  logic                  ws_prev_q, ws_prev_d;
  logic                  prev_vld_q, prev_vld_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] left_word_q, left_word_d;
  logic                  left_have_q, left_have_d;

  // One-cycle staging of a completed frame ahead of the output registers.
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] pend_left_q, pend_left_d;
  logic [DATA_WIDTH-1:0] pend_right_q, pend_right_d;

  // Output registers.
  logic [DATA_WIDTH-1:0] left_data_q, left_data_d;
  logic [DATA_WIDTH-1:0] right_data_q, right_data_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  overrun_q, overrun_d;

  logic                  sclk_rise;
  logic                  ws_tr;
  logic [CW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] word_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      ws_s1_q   <= 1'b0;
      ws_s2_q   <= 1'b0;
      sd_s1_q   <= 1'b0;
      sd_s2_q   <= 1'b0;
    end else begin
      sclk_s1_q <= bus.sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      ws_s1_q   <= bus.ws;
      ws_s2_q   <= ws_s1_q;
      sd_s1_q   <= bus.sd;
      sd_s2_q   <= sd_s1_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  // No transition is reported until one edge has been seen since reset, so the
  // cleared ws_prev cannot fake a WS change on the first edge.
  assign ws_tr     = sclk_rise & prev_vld_q & (ws_s2_q ^ ws_prev_q);

  // Word at commit: the closing-edge bit is the LSB when there is still room,
  // then any missing LSBs are zero-filled by left-aligning the collected bits.
  assign shamt  = DW_C - CW'(1) - cnt_q;
  assign word_c = (cnt_q < DW_C) ? ({sr_q[DATA_WIDTH-2:0], sd_s2_q} << shamt) : sr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RESET;
      ws_prev_q     <= 1'b0;
      prev_vld_q    <= 1'b0;
      cnt_q         <= '0;
      sr_q          <= '0;
      left_word_q   <= '0;
      left_have_q   <= 1'b0;
      pend_q        <= 1'b0;
      pend_left_q   <= '0;
      pend_right_q  <= '0;
      left_data_q   <= '0;
      right_data_q  <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ws_prev_q     <= ws_prev_d;
      prev_vld_q    <= prev_vld_d;
      cnt_q         <= cnt_d;
      sr_q          <= sr_d;
      left_word_q   <= left_word_d;
      left_have_q   <= left_have_d;
      pend_q        <= pend_d;
      pend_left_q   <= pend_left_d;
      pend_right_q  <= pend_right_d;
      left_data_q   <= left_data_d;
      right_data_q  <= right_data_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ws_prev_d    = ws_prev_q;
    prev_vld_d   = prev_vld_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    left_word_d  = left_word_q;
    left_have_d  = left_have_q;
    pend_d       = 1'b0;
    pend_left_d  = pend_left_q;
    pend_right_d = pend_right_q;

    if (sclk_rise) begin
      ws_prev_d  = ws_s2_q;
      prev_vld_d = 1'b1;
    end

    unique case (state_q)
      ST_RESET: begin
        state_d = ST_IDLE;
      end

      ST_IDLE: begin
        // The partial word before the first WS change is never collected.
        if (enable_i && ws_tr) begin
          state_d     = ws_s2_q ? ST_RIGHT : ST_LEFT;
          cnt_d       = '0;
          sr_d        = '0;
          left_have_d = 1'b0;
        end
      end

      ST_LEFT, ST_RIGHT: begin
        if (!enable_i) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          sr_d        = '0;
          left_have_d = 1'b0;
        end else if (ws_tr) begin
          state_d = ws_s2_q ? ST_RIGHT : ST_LEFT;
          cnt_d   = '0;
          sr_d    = '0;
          if (state_q == ST_LEFT) begin
            left_word_d = word_c;
            left_have_d = 1'b1;
            if (MONO) begin
              pend_d       = 1'b1;
              pend_left_d  = word_c;
              pend_right_d = '0;
            end
          end else if (!MONO && left_have_q) begin
            // Stereo frame closes on the right word; a right word with no
            // left partner (first slot after sync) is silently dropped.
            pend_d       = 1'b1;
            pend_left_d  = left_word_q;
            pend_right_d = word_c;
            left_have_d  = 1'b0;
          end
        end else if (sclk_rise && (cnt_q < DW_C)) begin
          sr_d  = {sr_q[DATA_WIDTH-2:0], sd_s2_q};
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output stage: load on a staged frame, clear valid on acceptance. A frame
  // landing in the acceptance cycle keeps valid high and is not an overrun.
  always_comb begin
    left_data_d   = left_data_q;
    right_data_d  = right_data_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = 1'b0;
    if (pend_q) begin
      left_data_d   = pend_left_q;
      right_data_d  = pend_right_q;
      frame_valid_d = 1'b1;
      overrun_d     = frame_valid_q & ~bus.frame_ready;
    end else if (frame_valid_q && bus.frame_ready) begin
      frame_valid_d = 1'b0;
    end
  end

  assign bus.left_data   = left_data_q;
  assign bus.right_data  = right_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.overrun_err = overrun_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_i2s_rx_slave_deserializer.sv
// Bench for the I2S slave deserializer: stereo and mono instances share one serial bus.
// Table of directed frames, hand-written overrun/mono/reset sequences, random frames vs a word model.
module tb_i2s_rx_slave_deserializer;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       sclk;
  logic       ws;
  logic       sd;
  logic       ready;
  logic [2:0] st_s;
  logic [2:0] st_m;

  int n_checks = 0;
  int n_fail   = 0;

  i2s_rx_slave_deserializer_if #(.DATA_WIDTH(DW)) bus_s ();
  i2s_rx_slave_deserializer_if #(.DATA_WIDTH(DW)) bus_m ();

  assign bus_s.sclk        = sclk;
  assign bus_s.ws          = ws;
  assign bus_s.sd          = sd;
  assign bus_s.frame_ready = ready;
  assign bus_m.sclk        = sclk;
  assign bus_m.ws          = ws;
  assign bus_m.sd          = sd;
  assign bus_m.frame_ready = 1'b1;

  i2s_rx_slave_deserializer #(.DATA_WIDTH(DW), .NUM_OF_CHANNELS(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .bus(bus_s), .state_o(st_s)
  );
  i2s_rx_slave_deserializer #(.DATA_WIDTH(DW), .NUM_OF_CHANNELS(1)) dut_m (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .bus(bus_m), .state_o(st_m)
  );

  always #5 clk = ~clk;

  // Accepted frames and overrun pulses, sampled mid-cycle.
  logic [7:0] acc_l[$];
  logic [7:0] acc_r[$];
  logic [7:0] mono_l[$];
  logic [7:0] mono_r[$];
  int         ovr_cnt = 0;

  always begin
    @(negedge clk);
    #1;
    if (bus_s.frame_valid && ready) begin
      acc_l.push_back(bus_s.left_data);
      acc_r.push_back(bus_s.right_data);
    end
    if (bus_s.overrun_err) ovr_cnt++;
    if (bus_m.frame_valid) begin
      mono_l.push_back(bus_m.left_data);
      mono_r.push_back(bus_m.right_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Serial stream: one bit per SCLK period; ws for each bit is the slot of the
  // following bit, so WS leads the MSB of each word by one SCLK.
  logic bits_q[$];
  logic slot_ws_q[$];

  task automatic add_slot(input logic wsv, input int n, input logic [31:0] v);
    for (int i = n - 1; i >= 0; i--) begin
      bits_q.push_back(v[i]);
      slot_ws_q.push_back(wsv);
    end
  endtask

  task automatic send_stream();
    for (int j = 0; j < bits_q.size(); j++) begin
      sd = bits_q[j];
      ws = (j + 1 < bits_q.size()) ? slot_ws_q[j+1] : slot_ws_q[j];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    bits_q.delete();
    slot_ws_q.delete();
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_frames(input string name, input int n);
    int k = 0;
    while (acc_l.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(acc_l.size()), 32'(n));
  endtask

  task automatic clear_acc();
    acc_l.delete();
    acc_r.delete();
    mono_l.delete();
    mono_r.delete();
    ovr_cnt = 0;
  endtask

  // Drop the receiver to IDLE, discarding the trailing partial word.
  task automatic flush(input string name);
    enable = 1'b0;
    @(negedge clk);
    check(name, 32'(st_s), 32'd2);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Reference: keep the first DW transmitted bits, MSB first, zero-fill short words.
  function automatic logic [7:0] model_word(input int n, input logic [31:0] v);
    logic [31:0] t;
    if (n >= DW) t = v >> (n - DW);
    else         t = v << (DW - n);
    return t[7:0];
  endfunction

  typedef struct {
    int          ln;
    logic [31:0] lv;
    int          rn;
    logic [31:0] rv;
    logic [7:0]  el;
    logic [7:0]  er;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [7:0] exp_l[$];
    logic [7:0] exp_r[$];

    tbl[0] = '{8,  32'hA5,      8,  32'h3C,      8'hA5, 8'h3C};
    tbl[1] = '{16, 32'hA55A,    16, 32'h1234,    8'hA5, 8'h12};
    tbl[2] = '{6,  32'b101101,  6,  32'b000111,  8'hB4, 8'h1C};
    tbl[3] = '{1,  32'h0,       8,  32'h99,      8'h00, 8'h99};

    rst = 1'b1; enable = 1'b1; sclk = 1'b0; ws = 1'b0; sd = 1'b0; ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state",   32'(st_s), 32'd1);
    check("reset_left",    32'(bus_s.left_data), 32'd0);
    check("reset_right",   32'(bus_s.right_data), 32'd0);
    check("reset_valid",   32'(bus_s.frame_valid), 32'd0);
    check("reset_overrun", 32'(bus_s.overrun_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(st_s), 32'd2);

    // Directed frames: exact words, truncation, zero fill, one-bit glitch slot.
    for (int t = 0; t < 4; t++) begin
      clear_acc();
      add_slot(1'b1, 3, 32'b101);
      add_slot(1'b0, tbl[t].ln, tbl[t].lv);
      add_slot(1'b1, tbl[t].rn, tbl[t].rv);
      add_slot(1'b0, 2, 32'b11);
      send_stream();
      wait_frames($sformatf("tbl%0d_count", t), 1);
      if (acc_l.size() > 0) begin
        check($sformatf("tbl%0d_left", t),  32'(acc_l[0]), 32'(tbl[t].el));
        check($sformatf("tbl%0d_right", t), 32'(acc_r[0]), 32'(tbl[t].er));
      end
      check($sformatf("tbl%0d_overrun", t), 32'(ovr_cnt), 32'd0);
      flush($sformatf("tbl%0d_disable_idle", t));
    end

    // Overrun: two frames with ready low, then accept.
    clear_acc();
    ready = 1'b0;
    add_slot(1'b1, 3, 32'b010);
    add_slot(1'b0, 8, 32'h11);
    add_slot(1'b1, 8, 32'h22);
    add_slot(1'b0, 8, 32'h33);
    add_slot(1'b1, 8, 32'h44);
    add_slot(1'b0, 2, 32'b00);
    send_stream();
    check("ovr_pulses", 32'(ovr_cnt), 32'd1);
    check("ovr_valid_held", 32'(bus_s.frame_valid), 32'd1);
    check("ovr_left", 32'(bus_s.left_data), 32'h33);
    check("ovr_right", 32'(bus_s.right_data), 32'h44);
    ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_drop", 32'(bus_s.frame_valid), 32'd0);
    #2;
    check("ovr_accepted", 32'(acc_l.size()), 32'd1);
    flush("ovr_disable_idle");

    // Mono instance: frame at left commit, right held at zero.
    clear_acc();
    add_slot(1'b1, 3, 32'b110);
    add_slot(1'b0, 8, 32'h5A);
    add_slot(1'b1, 8, 32'hFF);
    add_slot(1'b0, 2, 32'b01);
    send_stream();
    check("mono_count", 32'(mono_l.size()), 32'd1);
    if (mono_l.size() > 0) begin
      check("mono_left", 32'(mono_l[0]), 32'h5A);
      check("mono_right", 32'(mono_r[0]), 32'h00);
    end
    flush("mono_disable_idle");

    // Reset in the middle of a left word, then a clean frame.
    clear_acc();
    add_slot(1'b1, 3, 32'b101);
    add_slot(1'b0, 4, 32'b1000);
    send_stream();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state1", 32'(st_s), 32'd1);
    @(negedge clk);
    check("midrst_valid", 32'(bus_s.frame_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_state2", 32'(st_s), 32'd2);
    add_slot(1'b1, 3, 32'b011);
    add_slot(1'b0, 8, 32'h81);
    add_slot(1'b1, 8, 32'h7E);
    add_slot(1'b0, 2, 32'b10);
    send_stream();
    wait_frames("midrst_count", 1);
    repeat (20) @(negedge clk);
    check("midrst_single", 32'(acc_l.size()), 32'd1);
    if (acc_l.size() > 0) begin
      check("midrst_left", 32'(acc_l[0]), 32'h81);
      check("midrst_right", 32'(acc_r[0]), 32'h7E);
    end
    flush("midrst_disable_idle");

    // Random word lengths and contents against the word model.
    for (int it = 0; it < 3; it++) begin
      clear_acc();
      exp_l.delete();
      exp_r.delete();
      add_slot(1'b1, 3, 32'b100);
      for (int k = 0; k < 6; k++) begin
        int          ln;
        int          rn;
        logic [31:0] lv;
        logic [31:0] rv;
        ln = $urandom_range(1, 12);
        rn = $urandom_range(1, 12);
        lv = $urandom & ((32'd1 << ln) - 32'd1);
        rv = $urandom & ((32'd1 << rn) - 32'd1);
        add_slot(1'b0, ln, lv);
        add_slot(1'b1, rn, rv);
        exp_l.push_back(model_word(ln, lv));
        exp_r.push_back(model_word(rn, rv));
      end
      add_slot(1'b0, 2, 32'b11);
      send_stream();
      wait_frames($sformatf("rnd%0d_count", it), 6);
      for (int k = 0; k < 6 && k < acc_l.size(); k++) begin
        check($sformatf("rnd%0d_f%0d_left", it, k),  32'(acc_l[k]), 32'(exp_l[k]));
        check($sformatf("rnd%0d_f%0d_right", it, k), 32'(acc_r[k]), 32'(exp_r[k]));
      end
      check($sformatf("rnd%0d_overrun", it), 32'(ovr_cnt), 32'd0);
      flush($sformatf("rnd%0d_disable_idle", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
